// File: rtl/mac_frame_scheduler.sv
// Round-robin arbiter sharing one mac_frame_generator between N_REQ sources.
// Sequences load/start/wait-done/gap and tracks frames and timeouts.
module mac_frame_scheduler #(
  parameter int N_REQ            = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int START_CYCLES     = 2,
  parameter int IPG_CYCLES       = 12,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*8-1:0] i_req_mode,
  input  logic [N_REQ*16-1:0] i_req_len,
  input  logic               i_gen_done,
  output logic               o_gen_start,
  output logic [7:0]         o_gen_mode,
  output logic [15:0]        o_gen_length,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_frame_valid,
  output logic               o_busy,
  output logic               o_len_clamped,
  output logic               o_timeout_err,
  output logic [31:0]        o_frame_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE, S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     cnt, cnt_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            found;
  logic            to_hit;
  logic [15:0]     win_len;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && i_req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign win_len = i_req_len[16*win +: 16];

  // done lags start by a registered cycle, so the first wait cycle ignores it
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    to_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_enable && found) state_nx = S_LOAD;
      end
      S_LOAD: begin
        state_nx = S_START;
        cnt_nx   = 16'd1;
      end
      S_START: begin
        if (cnt == 16'(START_CYCLES)) begin
          state_nx = S_WAIT;
          cnt_nx   = 16'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_WAIT: begin
        if (i_gen_done && cnt != 16'd1) begin
          state_nx = S_DONE;
        end else if (cnt == 16'(TIMEOUT_CYCLES)) begin
          to_hit   = 1'b1;
          state_nx = (IPG_CYCLES == 0) ? S_IDLE : S_GAP;
          cnt_nx   = 16'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_DONE: begin
        state_nx = (IPG_CYCLES == 0) ? S_IDLE : S_GAP;
        cnt_nx   = 16'd1;
      end
      S_GAP: begin
        if (cnt == 16'(IPG_CYCLES)) state_nx = S_IDLE;
        else cnt_nx = cnt + 16'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      ptr           <= '0;
      o_grant       <= '0;
      o_gen_mode    <= '0;
      o_gen_length  <= '0;
      o_len_clamped <= 1'b0;
      o_timeout_err <= 1'b0;
      o_frame_count <= '0;
    end else begin
      if (state == S_IDLE && state_nx == S_LOAD) begin
        o_grant    <= N_REQ'(1) << win;
        o_gen_mode <= i_req_mode[8*win +: 8];
        if (win_len > 16'(PAYLOAD_MAX_SIZE)) begin
          o_gen_length  <= 16'(PAYLOAD_MAX_SIZE);
          o_len_clamped <= 1'b1;
        end else begin
          o_gen_length <= win_len;
        end
        ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
      end
      if (to_hit) o_timeout_err <= 1'b1;
      if (state == S_DONE) o_frame_count <= o_frame_count + 32'd1;
      if (state != S_IDLE && state_nx == S_IDLE) o_grant <= '0;
    end
  end

  assign o_gen_start   = (state == S_START);
  assign o_frame_valid = (state == S_DONE);
  assign o_ack         = (state == S_DONE) ? o_grant : '0;
  assign o_busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mac_frame_scheduler.sv
// Directed bench for mac_frame_scheduler: arbitration order, timing,
// clamping, timeout, enable/commit and mid-frame reset.
module tb_mac_frame_scheduler;

  logic        clk;
  logic        i_rst;
  logic        i_enable;
  logic [3:0]  i_req;
  logic [31:0] i_req_mode;
  logic [63:0] i_req_len;
  logic        i_gen_done;
  logic        o_gen_start;
  logic [7:0]  o_gen_mode;
  logic [15:0] o_gen_length;
  logic [3:0]  o_grant;
  logic [3:0]  o_ack;
  logic        o_frame_valid;
  logic        o_busy;
  logic        o_len_clamped;
  logic        o_timeout_err;
  logic [31:0] o_frame_count;

  int total = 0;
  int bad   = 0;

  mac_frame_scheduler dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_req         (i_req),
    .i_req_mode    (i_req_mode),
    .i_req_len     (i_req_len),
    .i_gen_done    (i_gen_done),
    .o_gen_start   (o_gen_start),
    .o_gen_mode    (o_gen_mode),
    .o_gen_length  (o_gen_length),
    .o_grant       (o_grant),
    .o_ack         (o_ack),
    .o_frame_valid (o_frame_valid),
    .o_busy        (o_busy),
    .o_len_clamped (o_len_clamped),
    .o_timeout_err (o_timeout_err),
    .o_frame_count (o_frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    while (o_grant != 4'd0 && n < 300) begin
      tick();
      n++;
    end
    while (o_grant == 4'd0 && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) chk("wait_grant_bound", 32'(n), 32'd0);
    g = o_grant;
  endtask

  task automatic wait_valid(output logic [3:0] a);
    int n;
    n = 0;
    while (!o_frame_valid && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_valid_bound", 32'(n), 32'd0);
    a = o_ack;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_idle_bound", 32'(n), 32'd0);
  endtask

  logic [3:0] g;
  logic [3:0] a;
  int n, nv, na;
  logic [3:0] rr_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_b [3] = '{4'b1000, 4'b0010, 4'b1000};

  initial begin
    i_rst = 1'b1;
    i_enable = 1'b0;
    i_req = '0;
    i_req_mode = '0;
    i_req_len = '0;
    i_gen_done = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_count", o_frame_count, 32'd0);
    chk("rst_start", 32'(o_gen_start), 32'd0);
    i_rst = 1'b0;
    tick();

    // single frame timing
    i_enable = 1'b1;
    i_gen_done = 1'b1;
    i_req_mode[7:0] = 8'd1;
    i_req_len[15:0] = 16'd46;
    i_req = 4'b0001;
    tick();
    chk("load_grant", 32'(o_grant), 32'd1);
    chk("load_start", 32'(o_gen_start), 32'd0);
    chk("load_mode", 32'(o_gen_mode), 32'd1);
    chk("load_len", 32'(o_gen_length), 32'd46);
    i_req = 4'b0000;
    tick();
    chk("start1", 32'(o_gen_start), 32'd1);
    tick();
    chk("start2", 32'(o_gen_start), 32'd1);
    tick();
    chk("wait1_start", 32'(o_gen_start), 32'd0);
    tick();
    chk("wait2_valid", 32'(o_frame_valid), 32'd0);
    tick();
    chk("done_valid", 32'(o_frame_valid), 32'd1);
    chk("done_ack", 32'(o_ack), 32'd1);
    tick();
    chk("gap_count", o_frame_count, 32'd1);
    chk("gap_valid", 32'(o_frame_valid), 32'd0);
    chk("gap_ack", 32'(o_ack), 32'd0);
    chk("gap_grant", 32'(o_grant), 32'd1);
    i_req = 4'b0001;
    n = 1;
    while (o_busy && n < 60) begin
      tick();
      n++;
    end
    chk("gap_len", 32'(n), 32'd13);
    chk("idle_grant", 32'(o_grant), 32'd0);
    tick();
    chk("regrant", 32'(o_grant), 32'd1);

    // round robin, all requesting
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      chk("rr_all", 32'(g), 32'(rr_a[i]));
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    wait_grant(g);
    chk("rr_b0", 32'(g), 32'd1);
    wait_grant(g);
    chk("rr_b1", 32'(g), 32'd2);
    i_req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      wait_grant(g);
      chk("rr_1010", 32'(g), 32'(rr_b[i]));
    end

    // clamp
    i_req = 4'b0001;
    i_req_len[15:0] = 16'd1600;
    wait_grant(g);
    chk("clamp_grant", 32'(g), 32'd1);
    chk("clamp_len", 32'(o_gen_length), 32'd1500);
    chk("clamp_flag", 32'(o_len_clamped), 32'd1);
    i_req_len[15:0] = 16'd60;
    wait_grant(g);
    chk("unclamp_len", 32'(o_gen_length), 32'd60);
    chk("clamp_sticky", 32'(o_len_clamped), 32'd1);
    i_req = 4'b0000;
    wait_idle();
    chk("count_7", o_frame_count, 32'd7);

    // timeout
    i_gen_done = 1'b0;
    i_req_len[15:0] = 16'd46;
    i_req = 4'b0001;
    wait_grant(g);
    chk("to_grant", 32'(g), 32'd1);
    nv = 0;
    na = 0;
    repeat (66) begin
      tick();
      nv += int'(o_frame_valid);
      na += int'(o_ack != 4'd0);
    end
    chk("to_before", 32'(o_timeout_err), 32'd0);
    tick();
    chk("to_flag", 32'(o_timeout_err), 32'd1);
    n = 0;
    while (o_busy && n < 100) begin
      tick();
      n++;
      nv += int'(o_frame_valid);
      na += int'(o_ack != 4'd0);
    end
    chk("to_idle", 32'(o_busy), 32'd0);
    chk("to_novalid", 32'(nv), 32'd0);
    chk("to_noack", 32'(na), 32'd0);
    chk("to_count", o_frame_count, 32'd7);
    i_gen_done = 1'b1;
    wait_grant(g);
    chk("to_recover", 32'(g), 32'd1);
    i_req = 4'b0000;
    wait_valid(a);
    chk("to_rec_ack", 32'(a), 32'd1);
    tick();
    chk("count_8", o_frame_count, 32'd8);

    // enable drop after commit
    i_req = 4'b1111;
    wait_grant(g);
    chk("en_grant", 32'(g), 32'd2);
    tick();
    i_enable = 1'b0;
    i_req = 4'b0000;
    wait_valid(a);
    chk("en_ack", 32'(a), 32'd2);
    tick();
    chk("count_9", o_frame_count, 32'd9);
    i_req = 4'b1111;
    repeat (40) tick();
    chk("en_block_grant", 32'(o_grant), 32'd0);
    chk("en_block_busy", 32'(o_busy), 32'd0);
    chk("en_block_count", o_frame_count, 32'd9);

    // reset in WAIT_DONE
    i_enable = 1'b1;
    i_req = 4'b0001;
    wait_grant(g);
    chk("mr_grant", 32'(g), 32'd1);
    i_req = 4'b0000;
    repeat (3) tick();
    chk("mr_inwait", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mr_grant0", 32'(o_grant), 32'd0);
    chk("mr_busy0", 32'(o_busy), 32'd0);
    chk("mr_start0", 32'(o_gen_start), 32'd0);
    chk("mr_count0", o_frame_count, 32'd0);
    chk("mr_clamp0", 32'(o_len_clamped), 32'd0);
    chk("mr_to0", 32'(o_timeout_err), 32'd0);
    chk("mr_len0", 32'(o_gen_length), 32'd0);
    chk("mr_mode0", 32'(o_gen_mode), 32'd0);
    i_req = 4'b1001;
    wait_grant(g);
    chk("mr_ptr0", 32'(g), 32'd1);
    i_req = 4'b0100;
    wait_grant(g);
    chk("mr_src2", 32'(g), 32'd4);
    i_req = 4'b0000;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
